serial_alu_sequencer: RTL and testbench
=======================================

SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only when accepting (IDLE or DONE).
REQ-005 op  input  2  operation: 00 ADD, 01 SUB, 10 PADDSB, 11 reserved.
REQ-006 a  input  16  operand A; captured on the accepted start edge.
REQ-007 b  input  16  operand B; captured on the accepted start edge.
REQ-008 busy  output  1  high while in CALC.
REQ-009 done  output  1  high for exactly one cycle when the result is valid.
REQ-010 result  output  16  final result; held stable from done until the next accepted start.
REQ-011 flag_z, flag_v, flag_n  output  1 each  zero, overflow and negative flags for ADD/SUB.
REQ-012 flags_we  output  1  high with done only for ADD/SUB; low for PADDSB and reserved op.

Function
REQ-013 The block SHALL contain exactly one 4-bit carry-lookahead adder slice, time-shared across four nibble cycles.
REQ-014 The FSM SHALL have three states: IDLE, CALC, DONE.
- IDLE -> CALC on start.
- CALC -> DONE after nibble 3.
- DONE -> CALC on start, otherwise DONE -> IDLE.
REQ-015 On an accepted start edge the block SHALL:
- latch a, b and op;
- clear the nibble counter to 0;
- preset the carry register to 1 for SUB and 0 otherwise.
REQ-016 In CALC, each edge SHALL:
- compute nibble n = counter;
- write result bits [4n+3:4n];
- update the carry register from the slice carry-out;
- increment the counter.
REQ-017 Latency: with start accepted at edge k, nibbles SHALL be written at edges k+1..k+4, and done SHALL be high in the cycle following edge k+4.
REQ-018 SUB SHALL use the bitwise inverse of B with carry-in 1, i.e. A + ~B + 1.
REQ-019 ADD/SUB overflow SHALL be computed at nibble 3 from the operand sign bits (with B inverted for SUB) and the sum bit 15.
- On positive overflow, result SHALL be 0x7FFF.
- On negative overflow, result SHALL be 0x8000.
- Saturation SHALL replace the whole 16-bit word.
REQ-020 Flags for ADD/SUB, all computed on the saturated result:
- flag_v = overflow;
- flag_n = result[15];
- flag_z = (result == 0).
REQ-021 PADDSB SHALL run each nibble in pad mode:
- carry-in forced to 0 for every nibble; no carry propagates between nibbles;
- each nibble independently saturates to 0x7 on positive overflow and 0x8 on negative overflow.
REQ-022 For PADDSB and reserved op, flag_z/v/n SHALL read 0 and flags_we SHALL be 0.
REQ-023 Reserved op (11) SHALL run the same 4-cycle sequence, produce result 0x0000 and assert done.
REQ-024 start SHALL be ignored while busy; captured operands and the sequence SHALL be unaffected.
REQ-025 start asserted during DONE SHALL be accepted, giving back-to-back operations with one done cycle between them.
REQ-026 Input changes on a and b after the accepted start edge SHALL NOT affect the result.

Reset
REQ-027 rst_n low SHALL immediately force:
- state IDLE;
- counter 0 and carry register 0;
- busy 0, done 0;
- result 0x0000;
- all flags 0 and flags_we 0.
REQ-028 Reset asserted mid-CALC SHALL abort the operation; no done SHALL follow the release of reset.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-030 ADD a=0x1234 b=0x0101 -> result 0x1335, V=0 N=0 Z=0, flags_we=1, done exactly 4 cycles after the start edge, busy high for 4 cycles.
REQ-031 ADD a=0x7000 b=0x1000 -> result 0x7FFF, V=1 N=0 Z=0.
REQ-032 SUB a=0x8000 b=0x0001 -> result 0x8000, V=1 N=1; SUB a=0x0005 b=0x0005 -> result 0x0000, Z=1 V=0.
REQ-033 PADDSB a=0x7F18 b=0x1181 -> result 0x7099, flags_we=0, all flags 0.
REQ-034 start re-pulsed with new operands during CALC -> ignored, original result delivered; start in the DONE cycle -> second result 4 cycles later.
REQ-035 rst_n pulsed low at nibble 2 -> all outputs 0 asynchronously, no done; the next start completes normally.

Source files
------------

// File: rtl/serial_alu_sequencer.sv
// Serial 16-bit ALU: ADD, SUB and nibble-wise PADDSB built around a single
// 4-bit carry-lookahead slice that is reused over four nibble cycles.
module serial_alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        flags_we
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpPad = 2'b10;

    state_t      state_q;
    logic [15:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [1:0]  cnt_q;
    logic        carry_q;

    logic        is_sub, is_pad, is_addsub;
    logic [3:0]  na, nb, p, g, sum, nib_out;
    logic [4:0]  c;
    logic        ovf_pos, ovf_neg;
    logic [15:0] res_nib, res_word;

    always_comb begin
        is_sub    = (op_q == OpSub);
        is_pad    = (op_q == OpPad);
        is_addsub = (op_q == OpAdd) || is_sub;
        na        = a_q[{cnt_q, 2'b00} +: 4];
        nb        = b_q[{cnt_q, 2'b00} +: 4] ^ {4{is_sub}};

        // Carry-lookahead slice; pad mode cuts the inter-nibble carry.
        p    = na ^ nb;
        g    = na & nb;
        c[0] = is_pad ? 1'b0 : carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];

        // Sign-bit overflow of this nibble; at nibble 3 this is the word overflow.
        ovf_pos = ~na[3] & ~nb[3] & sum[3];
        ovf_neg = na[3] & nb[3] & ~sum[3];

        if (is_pad) begin
            nib_out = ovf_pos ? 4'h7 : (ovf_neg ? 4'h8 : sum);
        end else if (is_addsub) begin
            nib_out = sum;
        end else begin
            nib_out = 4'h0;
        end

        res_nib                      = result;
        res_nib[{cnt_q, 2'b00} +: 4] = nib_out;
        res_word = ovf_pos ? 16'h7FFF : (ovf_neg ? 16'h8000 : res_nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
            flag_n   <= 1'b0;
            flags_we <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done     <= 1'b0;
                    flags_we <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cnt_q   <= '0;
                        carry_q <= (op == OpSub);
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    carry_q <= c[4];
                    cnt_q   <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                        flags_we <= is_addsub;
                        if (is_addsub) begin
                            result <= res_word;
                            flag_v <= ovf_pos | ovf_neg;
                            flag_n <= res_word[15];
                            flag_z <= (res_word == 16'h0000);
                        end else begin
                            result <= res_nib;
                            flag_v <= 1'b0;
                            flag_n <= 1'b0;
                            flag_z <= 1'b0;
                        end
                    end else begin
                        result <= res_nib;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer: directed and random operations compared
// against an arithmetic reference model.
module tb_serial_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] result;
    logic        flag_z, flag_v, flag_n, flags_we;

    int vectors = 0;
    int errors  = 0;

    serial_alu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag_z   (flag_z),
        .flag_v   (flag_v),
        .flag_n   (flag_n),
        .flags_we (flags_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer arithmetic with clamping.
    task automatic model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] res, output logic v, output logic n,
                         output logic z, output logic we);
        int r;
        int sx, sy;
        logic [3:0] nx, ny;
        v = 1'b0; n = 1'b0; z = 1'b0; we = 1'b0; res = 16'h0;
        if (o == 2'b00 || o == 2'b01) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
            r  = (o == 2'b00) ? sx + sy : sx - sy;
            if (r > 32767) begin r = 32767; v = 1'b1; end
            if (r < -32768) begin r = -32768; v = 1'b1; end
            res = r[15:0];
            n   = res[15];
            z   = (res == 16'h0);
            we  = 1'b1;
        end else if (o == 2'b10) begin
            for (int i = 0; i < 4; i++) begin
                nx = x[4*i +: 4];
                ny = y[4*i +: 4];
                r  = int'($signed(nx)) + int'($signed(ny));
                if (r > 7) r = 7;
                if (r < -8) r = -8;
                res[4*i +: 4] = r[3:0];
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit repulse);
        logic [15:0] er;
        logic ev, en, ez, ewe;
        int j, busy_cnt;
        model(o, x, y, er, ev, en, ez, ewe);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        op = 2'($urandom);
        j = 0;
        busy_cnt = 0;
        while (!done && j < 10) begin
            if (busy) busy_cnt++;
            if (repulse && j == 1) begin
                start = 1'b1; a = ~x; b = ~y;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        check("latency", 32'(j), 32'd4);
        check("busy_cycles", 32'(busy_cnt), 32'd4);
        check("busy_at_done", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(er));
        check("flags_vnz", {29'd0, flag_v, flag_n, flag_z}, {29'd0, ev, en, ez});
        check("flags_we", 32'(flags_we), 32'(ewe));
    endtask

    task automatic check_after_done(input logic [15:0] held);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(held));
    endtask

    initial begin
        int d;
        logic [15:0] held;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, result, flag_z, flag_v, flag_n, flags_we},
              '0);
        rst_n = 1'b1;

        // First start right on the first edge after reset release.
        do_op(2'b00, 16'h1234, 16'h0101, 1'b0);
        check_after_done(16'h1335);
        do_op(2'b00, 16'h7000, 16'h1000, 1'b0);
        check_after_done(16'h7FFF);
        do_op(2'b01, 16'h8000, 16'h0001, 1'b0);
        do_op(2'b01, 16'h0005, 16'h0005, 1'b0);   // back-to-back from DONE
        do_op(2'b10, 16'h7F18, 16'h1181, 1'b0);
        do_op(2'b11, 16'hFFFF, 16'h1234, 1'b0);
        check_after_done(16'h0000);
        do_op(2'b00, 16'h0F0F, 16'h00F1, 1'b1);   // re-pulse ignored while busy
        check_after_done(16'h1000);
        do_op(2'b01, 16'h1000, 16'h8000, 1'b0);   // SUB of most negative B

        // Reset during nibble 2 aborts the operation.
        @(negedge clk);
        op = 2'b00; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 {busy, done, result, flag_z, flag_v, flag_n, flags_we}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) d++;
        end
        check("no_done_after_abort", 32'(d), 32'd0);
        do_op(2'b00, 16'h4321, 16'h1111, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) @(negedge clk);
            do_op(2'($urandom), 16'($urandom), 16'($urandom), bit'($urandom_range(0, 3) == 0));
        end
        held = result;
        check_after_done(held);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
